// File: rtl/lifo_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_param_pkg
//  Description : Shared types and helpers for the parametrised LIFO.
//                The {write,read} request pair decodes to one of four opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package lifo_param_pkg;

   // Opcode encoding follows the {write, read} bit pair directly
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } op_e;

   // Occupancy counter width: must hold 0..depth inclusive
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_param_if
//  Description : Producer/consumer bundle for the parametrised LIFO.
//                master = the side issuing push/pop, slave = the stack itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lifo_param_if
   import lifo_param_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int CW = cnt_width(DEPTH);

   logic             write;
   logic             read;
   logic             clr_err;
   logic [WIDTH-1:0] datain;
   logic [WIDTH-1:0] dataout;
   logic             val;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output write, read, clr_err, datain,
      input  dataout, val, full, empty, almost_full, count, overflow, underflow
   );

   modport slave (
      input  write, read, clr_err, datain,
      output dataout, val, full, empty, almost_full, count, overflow, underflow
   );

endinterface
`default_nettype wire

// File: rtl/lifo_param_mem.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_param_mem
//  Description : WIDTH x DEPTH register array, one synchronous write port and
//                one registered read port. A read and write to the same
//                address in one cycle returns the old word (replace-top).
//                The read register can instead capture wdata (pass-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_param_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             we,
   input  wire logic [AW-1:0]    waddr,
   input  wire logic [WIDTH-1:0] wdata,
   input  wire logic             re,
   input  wire logic [AW-1:0]    raddr,
   input  wire logic             bypass,
   output logic      [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   // Storage write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output register: holds its value unless a pop or pass-through occurs
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (bypass) begin
         rdata <= wdata;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/lifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_param
//  Description : Parametrised synchronous LIFO with occupancy count,
//                registered status flags, replace-top on simultaneous
//                push+pop, and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_param
   import lifo_param_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 8,
   parameter int AFULL_LEVEL = DEPTH - 1
) (
   input  wire logic   clk,
   input  wire logic   rst,
   lifo_param_if.slave bus
);

   localparam int CW = cnt_width(DEPTH);
   localparam int AW = $clog2(DEPTH);

   op_e           op;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [CW-1:0] top_idx;
   logic [AW-1:0] top_addr;
   logic [AW-1:0] push_addr;
   logic          full_q;
   logic          empty_q;
   logic          afull_q;
   logic          val_q;
   logic          ovf_q;
   logic          unf_q;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic          rd_en;
   logic          bypass;
   logic          ovf_set;
   logic          unf_set;

   assign op        = op_e'({bus.write, bus.read});
   // Stack pointer is the count itself; top of stack lives at count-1
   assign top_idx   = count_q - CW'(1);
   assign top_addr  = top_idx[AW-1:0];
   assign push_addr = count_q[AW-1:0];

   // Request decode: refused operations leave the pointer untouched
   always_comb begin
      count_d   = count_q;
      mem_we    = 1'b0;
      mem_waddr = push_addr;
      rd_en     = 1'b0;
      bypass    = 1'b0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      case (op)
         OP_PUSH: begin
            if (full_q) begin
               ovf_set = 1'b1;
            end else begin
               mem_we  = 1'b1;
               count_d = count_q + CW'(1);
            end
         end
         OP_POP: begin
            if (empty_q) begin
               unf_set = 1'b1;
            end else begin
               rd_en   = 1'b1;
               count_d = count_q - CW'(1);
            end
         end
         OP_REPL: begin
            if (empty_q) begin
               bypass = 1'b1;
            end else begin
               rd_en     = 1'b1;
               mem_we    = 1'b1;
               mem_waddr = top_addr;
            end
         end
         default: begin
         end
      endcase
   end

   // Occupancy and status flags, registered from the next count
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         afull_q <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
         afull_q <= (count_d >= CW'(AFULL_LEVEL));
      end
   end

   // Valid strobe and sticky error flags; a new error beats clr_err
   always_ff @(posedge clk) begin
      if (rst) begin
         val_q <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         val_q <= rd_en | bypass;
         ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
         unf_q <= unf_set | (unf_q & ~bus.clr_err);
      end
   end

   lifo_param_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk    (clk),
      .rst    (rst),
      .we     (mem_we),
      .waddr  (mem_waddr),
      .wdata  (bus.datain),
      .re     (rd_en),
      .raddr  (top_addr),
      .bypass (bypass),
      .rdata  (bus.dataout)
   );

   assign bus.val         = val_q;
   assign bus.count       = count_q;
   assign bus.full        = full_q;
   assign bus.empty       = empty_q;
   assign bus.almost_full = afull_q;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_lifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lifo_param
//  Description : Self-checking bench for lifo_param (WIDTH=8, DEPTH=4,
//                AFULL_LEVEL=3). A queue-based stack model predicts every
//                cycle's outputs; a monitor compares them after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_param;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AFULL = 3;

   typedef struct {
      logic       val;
      logic [7:0] data;
      int         cnt;
      logic       full;
      logic       empty;
      logic       afull;
      logic       ovf;
      logic       unf;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   exp_t       exp_q[$];
   logic [7:0] stk[$];
   logic [7:0] m_data;
   logic       m_ovf;
   logic       m_unf;

   lifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   lifo_param #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFULL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock of stimulus; the model computes what the DUT should show after the edge
   task automatic cyc(input logic r, input logic w, input logic rd, input logic c, input logic [7:0] d);
      exp_t e;
      @(negedge clk);
      rst         = r;
      bus.write   = w;
      bus.read    = rd;
      bus.clr_err = c;
      bus.datain  = d;
      e.val = 1'b0;
      if (r) begin
         stk.delete();
         m_data = 8'h00;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (w && rd) begin
            e.val = 1'b1;
            if (stk.size() == 0) begin
               m_data = d;
            end else begin
               m_data = stk[stk.size()-1];
               stk[stk.size()-1] = d;
            end
         end else if (w) begin
            if (stk.size() < DEPTH) stk.push_back(d);
            else m_ovf = 1'b1;
         end else if (rd) begin
            if (stk.size() > 0) begin
               m_data = stk.pop_back();
               e.val  = 1'b1;
            end else begin
               m_unf = 1'b1;
            end
         end
      end
      e.data  = m_data;
      e.cnt   = stk.size();
      e.full  = (stk.size() == DEPTH);
      e.empty = (stk.size() == 0);
      e.afull = (stk.size() >= AFULL);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      exp_q.push_back(e);
   endtask

   task automatic push(input logic [7:0] d);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, d);
   endtask

   task automatic pop();
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic reset1();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Monitor: after every rising edge, compare DUT outputs to the oldest prediction
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("val",         int'(bus.val),         int'(e.val));
            chk("dataout",     int'(bus.dataout),     int'(e.data));
            chk("count",       int'(bus.count),       e.cnt);
            chk("full",        int'(bus.full),        int'(e.full));
            chk("empty",       int'(bus.empty),       int'(e.empty));
            chk("almost_full", int'(bus.almost_full), int'(e.afull));
            chk("overflow",    int'(bus.overflow),    int'(e.ovf));
            chk("underflow",   int'(bus.underflow),   int'(e.unf));
         end
      end
   end

   initial begin
      int rnd;
      n_cmp       = 0;
      n_bad       = 0;
      m_data      = 8'h00;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
      rst         = 1'b1;
      bus.write   = 1'b0;
      bus.read    = 1'b0;
      bus.clr_err = 1'b0;
      bus.datain  = 8'h00;

      // LIFO ordering
      reset1();
      push(8'h05); push(8'h08); push(8'h10);
      pop(); pop(); pop();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Fill, overflow, then pop top
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      push(8'h67);
      pop();

      // Underflow and clr_err, including clr coincident with a new error
      reset1();
      pop();
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Replace-top in the middle of the stack
      reset1();
      push(8'h40); push(8'h70);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h99);
      pop(); pop();

      // Pass-through on empty, replace-top at full
      reset1();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C);
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
      pop(); pop();

      // Reset with a pending read discards it
      reset1();
      push(8'h04); push(8'h03);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      pop();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         rnd = int'($urandom_range(0, 99));
         cyc(($urandom_range(0, 63) == 0),
             (rnd < 55),
             (rnd >= 35 && rnd < 85),
             ($urandom_range(0, 15) == 0),
             8'($urandom));
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Let the monitor drain, bounded
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
      #3;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
